pipeline_perf_counter: RTL
==========================

// Module: pipeline_perf_counter
// PURPOSE
//   Parametrised hardware performance-event counter bank for the pipelined CPU.
//   Counts RUN cycles plus NUM_EVENTS per-cycle event strobes (stall, flush, retire, ...)
//   while start_i is high, stops automatically after MAX_CYCLES, and exposes a snapshot
//   bank read by index. Replaces ad-hoc stall/flush counting with synthesizable counters.
// PARAMETERS
//   NUM_EVENTS  4   number of event inputs (>=1); bit0=stall, bit1=flush by convention
//   CNT_W       32  width of every counter
//   MAX_CYCLES  64  cycle limit; 0 = no limit; must be < 2**CNT_W
//   SAT_MODE    0   0 = counters wrap to 0 on overflow, 1 = counters saturate at all-ones
//   SEL_W       $clog2(NUM_EVENTS+1)  derived width of rd_sel_i (localparam)
// PORTS
//   clk_i        in   1             clock; all state updates on rising edge
//   rst_i        in   1             synchronous reset, active-high
//   start_i      in   1             level enable; counting runs while high
//   event_i      in   NUM_EVENTS    per-cycle event strobes, sampled every edge
//   clear_i      in   1             zero live, shadow and overflow state; go IDLE
//   snap_i       in   1             copy live counters into shadow bank
//   rd_sel_i     in   SEL_W         0 = cycle counter, k = event counter k-1 (k=1..NUM_EVENTS)
//   rd_data_o    out  CNT_W         registered shadow[rd_sel_i]
//   cycle_o      out  CNT_W         live cycle counter
//   limit_hit_o  out  1             one-cycle pulse on entry to DONE
//   overflow_o   out  NUM_EVENTS+1  sticky per-counter overflow, same indexing as rd_sel_i
//   state_o      out  2             00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
// BEHAVIOUR
//   Reset: all counters, shadow bank, rd_data_o, overflow_o, limit_hit_o = 0; state IDLE.
//   Priority per edge: rst_i > clear_i > (count update, snap_i, state transition).
//   FSM: IDLE -start_i=1-> RUN. RUN -start_i=0-> PAUSE. PAUSE -start_i=1-> RUN.
//        RUN -cycle count becomes MAX_CYCLES-> DONE (takes precedence over start_i=0).
//        DONE: hold until clear_i or rst_i -> IDLE. clear_i from any state -> IDLE.
//   Counting only in edges where registered state == RUN: cycle counter +1; event counter
//     k +1 iff event_i[k]=1. IDLE/PAUSE/DONE hold all counters; events ignored.
//   Latency: start_i first sampled high at edge N (IDLE) -> RUN after N; first increment at N+1.
//   Limit: at edge where cycle==MAX_CYCLES-1 in RUN, cycle -> MAX_CYCLES, events of that
//     cycle counted, state -> DONE, limit_hit_o=1 for exactly the following cycle.
//   Overflow: increment of an all-ones counter -> 0 (SAT_MODE=0) or stays all-ones
//     (SAT_MODE=1); corresponding overflow_o bit set, cleared only by clear_i/rst_i.
//   snap_i: shadow <= next-value of live counters (includes this edge's increment); any state.
//   rd_data_o <= shadow[rd_sel_i] each edge using pre-edge shadow (1-cycle latency);
//     snap_i and read in same cycle return old shadow; rd_sel_i > NUM_EVENTS -> 0.
//   clear_i with snap_i same edge: clear wins, shadow = 0; clear_i with start_i high
//     -> IDLE, re-enters RUN next edge. rst_i mid-RUN: everything zero next cycle.
// TESTING
//   1 rst, start_i=1 steady, event_i[0]=1 on 3 of first 10 RUN cycles, snap_i after 10th
//     -> rd_sel 0 gives 10, rd_sel 1 gives 3, rd_sel 2 gives 0, one cycle after select.
//   2 defaults, start_i held high -> cycle_o stops at 64, state_o=11, limit_hit_o exactly
//     one cycle; later event_i pulses leave counters unchanged.
//   3 start_i dropped 5 cycles at cycle_o=20 -> state_o=10, cycle_o stays 20; resume -> 21.
//   4 CNT_W=4, MAX_CYCLES=0, event_i[1]=1 for 17 RUN cycles -> SAT_MODE=0: counter=1,
//     overflow_o[2]=1; SAT_MODE=1: counter=15, overflow_o[2]=1; cycle overflow_o[0]=1.
//   5 clear_i+snap_i same edge in RUN with start_i=1 -> all counters/shadow/overflow 0,
//     state IDLE one cycle then RUN; rd_sel 0 reads 0.
//   6 rst_i asserted mid-RUN with clear_i=0, snap_i=1 -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/pipeline_perf_counter.sv
// Performance-event counter bank: a RUN-cycle counter plus NUM_EVENTS event counters,
// an automatic cycle limit, sticky overflow flags and a snapshot bank read by index.
module pipeline_perf_counter #(
    parameter int NUM_EVENTS = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 64,
    parameter int SAT_MODE   = 0,
    localparam int SEL_W     = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  clear_i,
    input  logic                  snap_i,
    input  logic [SEL_W-1:0]      rd_sel_i,
    output logic [CNT_W-1:0]      rd_data_o,
    output logic [CNT_W-1:0]      cycle_o,
    output logic                  limit_hit_o,
    output logic [NUM_EVENTS:0]   overflow_o,
    output logic [1:0]            state_o
);

    localparam int NC = NUM_EVENTS + 1;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    // Cycle value at which the next RUN edge reaches the limit.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt      [NC];
    logic [CNT_W-1:0] cnt_nxt  [NC];
    logic [CNT_W-1:0] shadow   [NC];
    logic [NC-1:0]    inc, ovf, ovf_set;
    logic             running, hit, lhit;
    logic [CNT_W-1:0] rd, rd_nxt;

    always_comb begin
        running = (state == RUN);
        hit     = running && (MAX_CYCLES != 0) && (cnt[0] == LAST);
        // Index 0 is the cycle counter, which increments on every RUN edge.
        inc     = running ? {event_i, 1'b1} : '0;
        ovf_set = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            cnt_nxt[i] = cnt[i];
            if (inc[i]) begin
                if (&cnt[i]) begin
                    ovf_set[i] = 1'b1;
                    cnt_nxt[i] = (SAT_MODE != 0) ? '1 : '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end

        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = RUN;
            RUN:     if (hit) state_nxt = DONE;
                     else if (!start_i) state_nxt = PAUSE;
            PAUSE:   if (start_i) state_nxt = RUN;
            default: state_nxt = state;
        endcase

        rd_nxt = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            if (rd_sel_i == SEL_W'(i)) rd_nxt = shadow[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            ovf   <= '0;
            lhit  <= 1'b0;
            rd    <= '0;
            for (int unsigned i = 0; i < NC; i++) begin
                cnt[i]    <= '0;
                shadow[i] <= '0;
            end
        end else if (clear_i) begin
            // The read port keeps sampling the pre-edge shadow even while clearing.
            state <= IDLE;
            ovf   <= '0;
            lhit  <= 1'b0;
            rd    <= rd_nxt;
            for (int unsigned i = 0; i < NC; i++) begin
                cnt[i]    <= '0;
                shadow[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            ovf   <= ovf | ovf_set;
            lhit  <= hit;
            rd    <= rd_nxt;
            for (int unsigned i = 0; i < NC; i++) begin
                cnt[i] <= cnt_nxt[i];
                if (snap_i) shadow[i] <= cnt_nxt[i];
            end
        end
    end

    assign rd_data_o   = rd;
    assign cycle_o     = cnt[0];
    assign limit_hit_o = lhit;
    assign overflow_o  = ovf;
    assign state_o     = state;

endmodule
